controlador_falta: RTL and testbench

- Miss/write-back sequencer between the L1 cache (cacheL1) and main memory (memoriaPrincipal).
- Accepts one access per request, classified by the cache as hit, clean miss or dirty miss.
- On a dirty miss it first writes the victim back to main memory, then reads the missing word and hands it to the cache as a fill.
- Replaces the combinational dirty-address/wren muxing at top level, so main memory sees exactly one well-timed operation per cycle.

---
 rtl/controlador_falta_if.sv | 37 +++
 rtl/controlador_falta.sv | 139 +++++++++++++
 tb/tb_controlador_falta.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/controlador_falta_if.sv
// Bundle of the cache-side request/fill handshake and the main-memory bus
// that the miss sequencer sits between.
interface controlador_falta_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_hit;
    logic              req_dirty;
    logic [ADDR_W-1:0] req_address;
    logic [ADDR_W-1:0] victim_address;
    logic [DATA_W-1:0] victim_data;
    logic              busy;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] mem_q;
    logic              fill_valid;
    logic [DATA_W-1:0] fill_data;
    logic              done;

    // Environment side: the cache issues requests, main memory returns mem_q.
    modport master (
        output req_valid, req_hit, req_dirty, req_address,
        output victim_address, victim_data, mem_q,
        input  busy, mem_wren, mem_address, mem_data,
        input  fill_valid, fill_data, done
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_hit, req_dirty, req_address,
        input  victim_address, victim_data, mem_q,
        output busy, mem_wren, mem_address, mem_data,
        output fill_valid, fill_data, done
    );
endinterface

// File: rtl/controlador_falta.sv
// Miss / write-back sequencer between the L1 cache and main memory.
// Every output is a register loaded from its next-cycle value, so main memory
// sees one clean operation per cycle and done/fill_valid are glitch-free.
// RD lasts 1 + MEM_LAT cycles: one cycle for the registered read address to
// reach the synchronous RAM, then MEM_LAT cycles until mem_q is valid.
module controlador_falta #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic                clock,
    input  logic                reset,
    controlador_falta_if.slave  bus,
    output logic [CNT_W-1:0]    miss_count,
    output logic [CNT_W-1:0]    wb_count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        FILL = 2'd3
    } state_t;

    localparam logic [3:0] LAT_END = 4'(MEM_LAT);

    state_t            state,       state_n;
    logic [3:0]        wait_cnt,    wait_n;
    logic [ADDR_W-1:0] req_addr,    req_addr_n;
    logic [CNT_W-1:0]  miss_n,      wb_n;
    logic              busy_n,      wren_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_data_n,  fill_data_n;
    logic              fill_valid_n, done_n;

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Next-state, next-output and counter update logic.
    always_comb begin
        state_n      = state;
        wait_n       = wait_cnt;
        req_addr_n   = req_addr;
        miss_n       = miss_count;
        wb_n         = wb_count;
        fill_data_n  = bus.fill_data;
        fill_valid_n = 1'b0;
        done_n       = 1'b0;
        case (state)
            IDLE: begin
                wait_n = 4'd0;
                if (bus.req_valid) begin
                    req_addr_n = bus.req_address;
                    if (bus.req_hit) begin
                        done_n = 1'b1;
                    end else if (bus.req_dirty) begin
                        state_n = WB;
                        miss_n  = sat_inc(miss_count);
                        wb_n    = sat_inc(wb_count);
                    end else begin
                        state_n = RD;
                        miss_n  = sat_inc(miss_count);
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            WB: begin
                state_n = RD;
                wait_n  = 4'd0;
            end
            RD: begin
                if (wait_cnt == LAT_END) begin
                    state_n      = FILL;
                    fill_valid_n = 1'b1;
                    done_n       = 1'b1;
                    fill_data_n  = bus.mem_q;
                end else begin
                    wait_n = wait_cnt + 4'd1;
                end
            end
            FILL: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // The victim address/data come straight from the inputs on the
        // accepting edge, so the WB registers act as the victim latch.
        busy_n = (state_n != IDLE);
        wren_n = (state_n == WB);
        if (state_n == WB) begin
            mem_addr_n = bus.victim_address;
            mem_data_n = bus.victim_data;
        end else begin
            mem_addr_n = req_addr_n;
            mem_data_n = {DATA_W{1'b0}};
        end
    end

    // State and output registers; reset aborts any sequence in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            wait_cnt        <= 4'd0;
            req_addr        <= {ADDR_W{1'b0}};
            miss_count      <= {CNT_W{1'b0}};
            wb_count        <= {CNT_W{1'b0}};
            bus.busy        <= 1'b0;
            bus.mem_wren    <= 1'b0;
            bus.mem_address <= {ADDR_W{1'b0}};
            bus.mem_data    <= {DATA_W{1'b0}};
            bus.fill_valid  <= 1'b0;
            bus.fill_data   <= {DATA_W{1'b0}};
            bus.done        <= 1'b0;
        end else begin
            state           <= state_n;
            wait_cnt        <= wait_n;
            req_addr        <= req_addr_n;
            miss_count      <= miss_n;
            wb_count        <= wb_n;
            bus.busy        <= busy_n;
            bus.mem_wren    <= wren_n;
            bus.mem_address <= mem_addr_n;
            bus.mem_data    <= mem_data_n;
            bus.fill_valid  <= fill_valid_n;
            bus.fill_data   <= fill_data_n;
            bus.done        <= done_n;
        end
    end
endmodule

// File: tb/tb_controlador_falta.sv
// Directed bench for controlador_falta with a 32-word synchronous RAM model
// (one cycle read latency, read-before-write on the same edge).
module tb_controlador_falta;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] miss_count;
    logic [7:0] wb_count;
    logic [7:0] mem [0:31];
    int         checks   = 0;
    int         failures = 0;
    int         lat;
    int         dcount;

    controlador_falta_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    controlador_falta #(.ADDR_W(5), .DATA_W(8), .MEM_LAT(1), .CNT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );

    always #5 clock = ~clock;

    // Main memory model, reloaded with known contents while reset is high.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= (i == 9) ? 8'd42 : (i == 3) ? 8'd10 : (i == 12) ? 8'd200 : 8'(i + 100);
            end
            bus.mem_q <= 8'd0;
        end else begin
            if (bus.mem_wren) mem[bus.mem_address] <= bus.mem_data;
            bus.mem_q <= mem[bus.mem_address];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one access for one edge; returns at the negedge after acceptance.
    task automatic accept(input logic hit, input logic dirty, input logic [4:0] addr,
                          input logic [4:0] vaddr, input logic [7:0] vdata);
        bus.req_valid      = 1'b1;
        bus.req_hit        = hit;
        bus.req_dirty      = dirty;
        bus.req_address    = addr;
        bus.victim_address = vaddr;
        bus.victim_data    = vdata;
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    // Step until done is seen (bounded); lat = cycle index of the done pulse.
    task automatic wait_done(input int start, output int l);
        l = start;
        while (!bus.done && l < 20) begin
            @(negedge clock);
            l++;
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_hit = 1'b0; bus.req_dirty = 1'b0;
        bus.req_address = 5'd0; bus.victim_address = 5'd0; bus.victim_data = 8'd0;
        repeat (2) @(negedge clock);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_wren", 32'(bus.mem_wren), 32'd0);
        check("rst_addr", 32'(bus.mem_address), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_fill", 32'(bus.fill_valid), 32'd0);
        check("rst_miss", 32'(miss_count), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Hit: done the cycle after acceptance, no memory activity.
        accept(1'b1, 1'b0, 5'd5, 5'd0, 8'd0);
        check("hit_done", 32'(bus.done), 32'd1);
        check("hit_busy", 32'(bus.busy), 32'd0);
        check("hit_wren", 32'(bus.mem_wren), 32'd0);
        check("hit_fill", 32'(bus.fill_valid), 32'd0);
        check("hit_addr", 32'(bus.mem_address), 32'd5);
        check("hit_miss", 32'(miss_count), 32'd0);
        @(negedge clock);
        check("hit_done_pulse", 32'(bus.done), 32'd0);

        // Clean miss to address 9: latency 1+1+1.
        accept(1'b0, 1'b0, 5'd9, 5'd0, 8'd0);
        check("clean_busy", 32'(bus.busy), 32'd1);
        check("clean_rd_addr", 32'(bus.mem_address), 32'd9);
        check("clean_rd_wren", 32'(bus.mem_wren), 32'd0);
        wait_done(1, lat);
        check("clean_lat", 32'(lat), 32'd3);
        check("clean_fill_valid", 32'(bus.fill_valid), 32'd1);
        check("clean_fill_data", 32'(bus.fill_data), 32'd42);
        check("clean_miss", 32'(miss_count), 32'd1);
        check("clean_wb", 32'(wb_count), 32'd0);
        @(negedge clock);
        check("clean_idle", 32'(bus.busy), 32'd0);

        // Dirty miss: write back 77 to 19, then read 3; a stray request is ignored.
        accept(1'b0, 1'b1, 5'd3, 5'd19, 8'd77);
        check("dirty_wren", 32'(bus.mem_wren), 32'd1);
        check("dirty_wb_addr", 32'(bus.mem_address), 32'd19);
        check("dirty_wb_data", 32'(bus.mem_data), 32'd77);
        bus.req_valid = 1'b1; bus.req_hit = 1'b1; bus.req_address = 5'd7;
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("dirty_rd_wren", 32'(bus.mem_wren), 32'd0);
        check("dirty_rd_addr", 32'(bus.mem_address), 32'd3);
        wait_done(2, lat);
        check("dirty_lat", 32'(lat), 32'd4);
        check("dirty_fill_data", 32'(bus.fill_data), 32'd10);
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (bus.done) dcount++;
        end
        check("dirty_no_second_done", 32'(dcount), 32'd0);
        check("dirty_mem19", 32'(mem[19]), 32'd77);
        check("dirty_miss", 32'(miss_count), 32'd2);
        check("dirty_wb", 32'(wb_count), 32'd1);

        // Dirty miss whose victim is the requested word: fill returns new data.
        accept(1'b0, 1'b1, 5'd12, 5'd12, 8'd55);
        wait_done(1, lat);
        check("same_lat", 32'(lat), 32'd4);
        check("same_fill_data", 32'(bus.fill_data), 32'd55);
        check("same_wb", 32'(wb_count), 32'd2);
        @(negedge clock);

        // Reset while in RD aborts the sequence.
        accept(1'b0, 1'b0, 5'd9, 5'd0, 8'd0);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_wren", 32'(bus.mem_wren), 32'd0);
        check("abort_fill", 32'(bus.fill_valid), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_miss", 32'(miss_count), 32'd0);
        check("abort_wb", 32'(wb_count), 32'd0);
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (bus.done || bus.fill_valid) dcount++;
        end
        check("abort_quiet", 32'(dcount), 32'd0);
        accept(1'b1, 1'b0, 5'd5, 5'd0, 8'd0);
        check("post_abort_hit_done", 32'(bus.done), 32'd1);
        @(negedge clock);

        // 260 clean misses: counter saturates at 255.
        for (int i = 0; i < 260; i++) begin
            accept(1'b0, 1'b0, 5'd9, 5'd0, 8'd0);
            wait_done(1, lat);
            if (i == 254) check("sat_at_255", 32'(miss_count), 32'd255);
            @(negedge clock);
        end
        check("sat_hold", 32'(miss_count), 32'd255);
        check("sat_wb", 32'(wb_count), 32'd0);
        check("sat_last_lat", 32'(lat), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
